// File: rtl/io_device_responder_if.sv
// ---------------------------------------------------------------------------
// io_device_responder_if
// Bundles the request port, the read-return port and the interrupt pins of
// io_device_responder.
//   iREQ/iRW/iADDR/iDATA : request from initiator, oBUSY stalls it
//   oREQ/oDATA           : read return to initiator, iBUSY stalls it
//   oIRQ_REQ/oIRQ_NUM    : interrupt request / number, iIRQ_ACK acknowledges
// Modport slave is the device side, master is the initiator side.
// ---------------------------------------------------------------------------
interface io_device_responder_if;
  logic        iREQ;
  logic        oBUSY;
  logic        iRW;
  logic [31:0] iADDR;
  logic [31:0] iDATA;
  logic        oREQ;
  logic        iBUSY;
  logic [31:0] oDATA;
  logic        oIRQ_REQ;
  logic [5:0]  oIRQ_NUM;
  logic        iIRQ_ACK;

  modport master (
    output iREQ, iRW, iADDR, iDATA, iBUSY, iIRQ_ACK,
    input  oBUSY, oREQ, oDATA, oIRQ_REQ, oIRQ_NUM
  );

  modport slave (
    input  iREQ, iRW, iADDR, iDATA, iBUSY, iIRQ_ACK,
    output oBUSY, oREQ, oDATA, oIRQ_REQ, oIRQ_NUM
  );
endinterface

// File: rtl/io_device_responder.sv
// ---------------------------------------------------------------------------
// io_device_responder
// Small memory-mapped IO device: control/size/limit/count/scratch registers,
// a free-running timer with terminal-count interrupt, and a 2-entry read
// return FIFO.
// Ports:
//   iCLOCK  : clock, rising edge
//   iRESET  : asynchronous active-high reset
//   bus     : io_device_responder_if.slave (request, read return, IRQ)
// Register map (iADDR[7:2]):
//   0x00 CTRL  {OVF, IEN, TEN}   0x04 SIZE (P_SIZE)   0x08 LIMIT
//   0x0C COUNT (RO)              0x10-0x1C SCR0-3     others read 0
// ---------------------------------------------------------------------------
module io_device_responder #(
  parameter logic [31:0] P_SIZE    = 32'h00000100,
  parameter logic [5:0]  P_IRQ_NUM = 6'h0
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  io_device_responder_if.slave  bus
);

  typedef enum logic [0:0] {
    IRQ_IDLE     = 1'b0,
    IRQ_WAIT_ACK = 1'b1
  } irq_state_t;

  logic        ten_q, ten_d, ien_q, ien_d, ovf_q, ovf_d;
  logic [31:0] limit_q, limit_d, count_q, count_d;
  logic [31:0] scr_q [4];
  logic [31:0] scr_d [4];
  logic [31:0] fifo_q [2];
  logic [31:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic        pend_q, pend_d;
  irq_state_t  state_q;
  logic        irq_req_q;

  logic        busy_s, accept_s, push_s, pop_s, wr_s, limit_wr_s;
  logic        term_s, ack_s, not_empty_s;
  logic [5:0]  idx_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign unused_s    = ^{bus.iADDR[31:8], bus.iADDR[1:0]};
  assign idx_s       = bus.iADDR[7:2];
  assign busy_s      = (fcnt_q == 2'd2);
  assign not_empty_s = (fcnt_q != 2'd0);
  assign accept_s    = bus.iREQ && !busy_s;
  assign push_s      = accept_s && !bus.iRW;
  assign wr_s        = accept_s && bus.iRW;
  assign pop_s       = not_empty_s && !bus.iBUSY;
  assign limit_wr_s  = wr_s && (idx_s == 6'd2);
  assign ack_s       = (state_q == IRQ_WAIT_ACK) && bus.iIRQ_ACK;
  // A LIMIT write restarts the timer, so it also suppresses the wrap event.
  assign term_s      = ten_q && (limit_q != 32'h0) && (count_q == limit_q) && !limit_wr_s;

  assign bus.oBUSY    = busy_s;
  assign bus.oREQ     = not_empty_s;
  assign bus.oDATA    = not_empty_s ? fifo_q[rd_ptr_q] : 32'h0;
  assign bus.oIRQ_REQ = irq_req_q;
  assign bus.oIRQ_NUM = P_IRQ_NUM;

  // Register read multiplexer
  always_comb begin
    rdata_s = 32'h0;
    case (idx_s)
      6'd0:    rdata_s = {29'h0, ovf_q, ien_q, ten_q};
      6'd1:    rdata_s = P_SIZE;
      6'd2:    rdata_s = limit_q;
      6'd3:    rdata_s = count_q;
      6'd4, 6'd5, 6'd6, 6'd7:
               rdata_s = scr_q[idx_s[1:0]];
      default: rdata_s = 32'h0;
    endcase
  end

  // Next-state for registers, timer, pending flag and read FIFO
  always_comb begin
    ten_d    = ten_q;
    ien_d    = ien_q;
    ovf_d    = ovf_q;
    limit_d  = limit_q;
    count_d  = count_q;
    scr_d    = scr_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q;

    if (wr_s) begin
      case (idx_s)
        6'd0: begin
          ten_d = bus.iDATA[0];
          ien_d = bus.iDATA[1];
          if (bus.iDATA[2]) begin
            ovf_d = 1'b0;
          end else begin
            ovf_d = ovf_q;
          end
        end
        6'd2:    limit_d = bus.iDATA;
        6'd4, 6'd5, 6'd6, 6'd7:
                 scr_d[idx_s[1:0]] = bus.iDATA;
        default: ; // RO and unmapped offsets ignore writes
      endcase
    end else begin
      ten_d = ten_q;
    end

    if (limit_wr_s) begin
      count_d = 32'h0;
    end else if (ten_q && (limit_q != 32'h0)) begin
      count_d = (count_q == limit_q) ? 32'h0 : (count_q + 32'd1);
    end else begin
      count_d = count_q;
    end

    // A second event before the first was acknowledged is an overflow;
    // setting wins over a simultaneous clear by CTRL write.
    if (term_s && pend_q && !ack_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end

    if (term_s) begin
      pend_d = 1'b1;
    end else if (ack_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (push_s) begin
      fifo_d[wr_ptr_q] = rdata_s;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Register, timer, pending-flag and FIFO state
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      ten_q    <= 1'b0;
      ien_q    <= 1'b0;
      ovf_q    <= 1'b0;
      limit_q  <= 32'h0;
      count_q  <= 32'h0;
      for (int i = 0; i < 4; i++) scr_q[i] <= 32'h0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= 32'h0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fcnt_q   <= 2'd0;
      pend_q   <= 1'b0;
    end else begin
      ten_q    <= ten_d;
      ien_q    <= ien_d;
      ovf_q    <= ovf_d;
      limit_q  <= limit_d;
      count_q  <= count_d;
      scr_q    <= scr_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      pend_q   <= pend_d;
    end
  end

  // IRQ FSM with registered request output; IEN only gates entry, not exit
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q   <= IRQ_IDLE;
      irq_req_q <= 1'b0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (pend_q && ien_q) begin
            state_q   <= IRQ_WAIT_ACK;
            irq_req_q <= 1'b1;
          end else begin
            state_q   <= IRQ_IDLE;
            irq_req_q <= 1'b0;
          end
        end
        IRQ_WAIT_ACK: begin
          if (bus.iIRQ_ACK) begin
            state_q   <= IRQ_IDLE;
            irq_req_q <= 1'b0;
          end else begin
            state_q   <= IRQ_WAIT_ACK;
            irq_req_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IRQ_IDLE;
          irq_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
